// File: rtl/peek_dump_ctrl.sv
// peek_dump_ctrl: walks core ids and word addresses through the debug peek port
// and streams each captured word out on a valid/ready interface.
module peek_dump_ctrl #(
   parameter int CORE_COUNT     = 9,
   parameter int WORDS_PER_CORE = 1024,
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int PEEK_LAT       = 1,
   localparam int ID_W          = $clog2(CORE_COUNT)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [ID_W-1:0]   first_id,
   input  logic [ID_W-1:0]   last_id,
   output logic [ADDR_W-1:0] peek_address,
   output logic [ID_W-1:0]   peek_id,
   input  logic [DATA_W-1:0] peek_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [ID_W-1:0]   out_id,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_last,
   output logic              busy,
   output logic              done,
   output logic              err
);
   typedef enum logic [1:0] {IDLE, WAIT, OUT} state_t;
   localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(WORDS_PER_CORE - 1);
   state_t            state, state_n;
   logic [2:0]        cnt, cnt_n;
   logic [ADDR_W-1:0] peek_address_n, out_addr_n;
   logic [ID_W-1:0]   peek_id_n, out_id_n, last_q, last_n;
   logic [DATA_W-1:0] out_data_n;
   logic              done_n, err_n, legal, wrap;
   assign legal     = first_id <= last_id && int'(last_id) < CORE_COUNT;
   assign wrap      = peek_address == ADDR_MAX;
   assign out_valid = state == OUT;
   assign busy      = state != IDLE;
   assign out_last  = out_valid && out_id == last_q && out_addr == ADDR_MAX;
   always_comb begin
      state_n        = state;
      cnt_n          = cnt;
      peek_address_n = peek_address;
      peek_id_n      = peek_id;
      out_data_n     = out_data;
      out_id_n       = out_id;
      out_addr_n     = out_addr;
      last_n         = last_q;
      done_n         = 1'b0;
      err_n          = 1'b0;
      if (state == IDLE) begin
         if (start && legal) begin
            state_n        = WAIT;
            cnt_n          = '0;
            peek_address_n = '0;
            peek_id_n      = first_id;
            last_n         = last_id;
         end else if (start) begin
            err_n = 1'b1;
         end
      end else if (abort) begin
         state_n = IDLE;
      end else if (state == WAIT) begin
         cnt_n = cnt + 3'd1;
         if (cnt == 3'(PEEK_LAT - 1)) begin
            state_n    = OUT;
            out_data_n = peek_data;
            out_id_n   = peek_id;
            out_addr_n = peek_address;
         end
      end else if (out_ready) begin
         // the peek port is only re-addressed here, on the way back into WAIT
         if (out_last) begin
            state_n = IDLE;
            done_n  = 1'b1;
         end else begin
            state_n        = WAIT;
            cnt_n          = '0;
            peek_address_n = wrap ? '0 : peek_address + 1'b1;
            peek_id_n      = wrap ? peek_id + 1'b1 : peek_id;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         peek_address <= '0;
         peek_id      <= '0;
         out_data     <= '0;
         out_id       <= '0;
         out_addr     <= '0;
         last_q       <= '0;
         done         <= 1'b0;
         err          <= 1'b0;
      end else begin
         state        <= state_n;
         cnt          <= cnt_n;
         peek_address <= peek_address_n;
         peek_id      <= peek_id_n;
         out_data     <= out_data_n;
         out_id       <= out_id_n;
         out_addr     <= out_addr_n;
         last_q       <= last_n;
         done         <= done_n;
         err          <= err_n;
      end
   end
endmodule

// File: tb/tb_peek_dump_ctrl.sv
// tb_peek_dump_ctrl: two dump controllers (latency 1 / 1024 words, latency 3 / 3 words)
// checked every cycle against a word-list model of the dump.
module tb_peek_dump_ctrl;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;
   typedef struct {int id; int a;} w_t;
   logic [1:0]  start = '0, abort = '0, ready = '0, ov, ol, busy, done, err;
   logic [3:0]  fid[2], lid[2], pid[2], oid[2];
   logic [31:0] paddr[2], pdata[2], odata[2], oaddr[2];
   int rmode[2];
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;
   function automatic logic [31:0] mem(logic [3:0] id, logic [31:0] a);
      return (a * 32'h9E3779B1) ^ ({28'd0, id} * 32'h01000193) ^ 32'h5A5AC3C3;
   endfunction
   function automatic int lat(int k);
      return k == 0 ? 1 : 3;
   endfunction
   function automatic int wpc(int k);
      return k == 0 ? 1024 : 3;
   endfunction
   for (genvar g = 0; g < 2; g++) begin : u
      logic [31:0] p1 = '0, p2 = '0;
      peek_dump_ctrl #(.CORE_COUNT(9), .WORDS_PER_CORE(g == 0 ? 1024 : 3), .ADDR_W(32),
                       .DATA_W(32), .PEEK_LAT(g == 0 ? 1 : 3)) dut (
         .clk(clk), .rst(rst), .start(start[g]), .abort(abort[g]),
         .first_id(fid[g]), .last_id(lid[g]), .peek_address(paddr[g]), .peek_id(pid[g]),
         .peek_data(pdata[g]), .out_valid(ov[g]), .out_ready(ready[g]), .out_data(odata[g]),
         .out_id(oid[g]), .out_addr(oaddr[g]), .out_last(ol[g]), .busy(busy[g]),
         .done(done[g]), .err(err[g]));
      // memory behind the port: combinational for latency 1, two register stages for latency 3
      always @(posedge clk) begin
         p1 <= mem(pid[g], paddr[g]);
         p2 <= p1;
      end
      assign pdata[g] = (g == 0) ? mem(pid[g], paddr[g]) : p2;
   end
   int nchk = 0, nfail = 0;
   task automatic chk(string nm, int k, logic [63:0] got, logic [63:0] exp);
      nchk++;
      if (got !== exp) begin
         nfail++;
         if (nfail < 40) $display("FAIL %s dut%0d: got %0h expected %0h", nm, k, got, exp);
      end
   endtask
   bit armed = 0;
   bit m_busy[2], m_valid[2], m_done[2], m_err[2], m_fresh[2];
   int m_wait[2], acc[2], ndone[2];
   logic [3:0]  m_pid[2];
   logic [31:0] m_paddr[2];
   w_t q[2][$];
   // compare current outputs, then advance the model with the inputs for the coming edge
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (armed) begin
            chk("busy", k, busy[k], m_busy[k]);
            chk("done", k, done[k], m_done[k]);
            chk("err", k, err[k], m_err[k]);
            chk("out_valid", k, ov[k], m_valid[k]);
            chk("peek_id", k, pid[k], m_pid[k]);
            chk("peek_address", k, paddr[k], m_paddr[k]);
            if (m_valid[k]) begin
               chk("out_data", k, odata[k], mem(4'(q[k][0].id), q[k][0].a));
               chk("out_id", k, oid[k], q[k][0].id);
               chk("out_addr", k, oaddr[k], q[k][0].a);
               chk("out_last", k, ol[k], q[k].size() == 1);
            end else chk("out_last_idle", k, ol[k], 0);
            if (m_fresh[k]) begin
               chk("out_data_rst", k, odata[k], 0);
               chk("out_id_rst", k, oid[k], 0);
               chk("out_addr_rst", k, oaddr[k], 0);
            end
         end
         m_done[k] = 0;
         m_err[k]  = 0;
         if (rst) begin
            m_busy[k] = 0; m_valid[k] = 0; m_pid[k] = 0; m_paddr[k] = 0; m_fresh[k] = 1;
            q[k].delete();
         end else if (!m_busy[k]) begin
            if (start[k] && fid[k] <= lid[k] && lid[k] < 9) begin
               for (int id = int'(fid[k]); id <= int'(lid[k]); id++)
                  for (int a = 0; a < wpc(k); a++) q[k].push_back('{id, a});
               m_busy[k] = 1; m_wait[k] = lat(k); m_fresh[k] = 0;
               m_pid[k] = fid[k]; m_paddr[k] = 0;
            end else if (start[k]) m_err[k] = 1;
         end else if (abort[k]) begin
            m_busy[k] = 0; m_valid[k] = 0;
            q[k].delete();
         end else if (m_valid[k]) begin
            if (ready[k]) begin
               void'(q[k].pop_front());
               acc[k]++;
               m_valid[k] = 0;
               if (q[k].size() == 0) begin
                  m_busy[k] = 0; m_done[k] = 1; ndone[k]++;
               end else begin
                  m_wait[k] = lat(k); m_pid[k] = 4'(q[k][0].id); m_paddr[k] = q[k][0].a;
               end
            end
         end else begin
            m_wait[k]--;
            if (m_wait[k] == 0) m_valid[k] = 1;
         end
      end
      armed = 1;
   end
   initial forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) ready[k] = rmode[k] == 0 ? 1'b1 : ($urandom_range(99) < 30);
   end
   task automatic go(int k, int f, int l, output int t);
      @(posedge clk);
      #1;
      start[k] = 1; fid[k] = 4'(f); lid[k] = 4'(l);
      @(posedge clk);
      #1;
      t = cyc;
      start[k] = 0;
   endtask
   task automatic wait_done(int k, int limit, output int t);
      bit seen = 0;
      t = -1;
      for (int i = 0; i < limit && !seen; i++) begin
         @(posedge clk);
         #1;
         if (done[k]) begin seen = 1; t = cyc; end
      end
      chk("done_seen", k, seen, 1);
   endtask
   initial begin
      int t0, t1, a0, d0;
      bit found;
      fid = '{4'd0, 4'd0}; lid = '{4'd0, 4'd0}; rmode = '{0, 0};
      acc = '{0, 0}; ndone = '{0, 0};
      repeat (2) @(posedge clk);
      #1 rst = 0;
      // single core, no stall
      a0 = acc[0];
      go(0, 0, 0, t0);
      wait_done(0, 3000, t1);
      chk("cycles_to_done", 0, t1 - t0, 2048);
      chk("words_core0", 0, acc[0] - a0, 1024);
      chk("done_count", 0, ndone[0], 1);
      // full dump with an ignored start midway
      a0 = acc[0];
      go(0, 0, 8, t0);
      repeat (500) @(posedge clk);
      #1 start[0] = 1; fid[0] = 4'd5; lid[0] = 4'd2;
      @(posedge clk);
      #1 start[0] = 0;
      wait_done(0, 20000, t1);
      chk("words_full", 0, acc[0] - a0, 9216);
      chk("cycles_full", 0, t1 - t0, 18432);
      // backpressure
      rmode[0] = 1;
      a0 = acc[0];
      go(0, 4, 4, t0);
      wait_done(0, 12000, t1);
      chk("words_stall", 0, acc[0] - a0, 1024);
      rmode[0] = 0;
      // illegal starts
      go(0, 5, 2, t0);
      chk("err_pulse_order", 0, err[0], 1);
      chk("busy_after_bad", 0, busy[0], 0);
      go(0, 5, 9, t0);
      chk("err_pulse_range", 0, err[0], 1);
      chk("busy_after_range", 0, busy[0], 0);
      // abort at word 300 of core 2, with out_ready and start both high
      a0 = acc[0]; d0 = ndone[0]; found = 0;
      go(0, 2, 4, t0);
      for (int i = 0; i < 2000 && !found; i++) begin
         @(posedge clk);
         #1;
         if (ov[0] && oid[0] == 4'd2 && oaddr[0] == 300) found = 1;
      end
      chk("abort_point_found", 0, found, 1);
      abort[0] = 1; start[0] = 1; fid[0] = 4'd3; lid[0] = 4'd3;
      @(posedge clk);
      #1 abort[0] = 0; start[0] = 0;
      chk("busy_after_abort", 0, busy[0], 0);
      chk("words_before_abort", 0, acc[0] - a0, 300);
      repeat (3) @(posedge clk);
      chk("no_done_on_abort", 0, ndone[0] - d0, 0);
      a0 = acc[0];
      go(0, 3, 3, t0);
      wait_done(0, 3000, t1);
      chk("words_after_abort", 0, acc[0] - a0, 1024);
      // reset mid-dump: no done pulse
      d0 = ndone[0];
      go(0, 0, 1, t0);
      repeat (50) @(posedge clk);
      #1 rst = 1;
      @(posedge clk);
      #1 rst = 0;
      repeat (4) @(posedge clk);
      #1 chk("no_done_on_reset", 0, ndone[0] - d0, 0);
      chk("busy_after_reset", 0, busy[0], 0);
      // latency 3, three words per core
      a0 = acc[1]; found = 0;
      go(1, 1, 2, t0);
      for (int i = 0; i < 20 && !found; i++) begin
         if (ov[1]) found = 1;
         else begin
            @(posedge clk);
            #1;
         end
      end
      chk("first_valid_seen", 1, found, 1);
      chk("first_valid_lat", 1, cyc - t0, 3);
      wait_done(1, 100, t1);
      chk("words_lat3", 1, acc[1] - a0, 6);
      chk("cycles_lat3", 1, t1 - t0, 24);
      rmode[1] = 1;
      a0 = acc[1];
      go(1, 0, 8, t0);
      wait_done(1, 2000, t1);
      chk("words_lat3_stall", 1, acc[1] - a0, 27);
      rmode[1] = 0;
      // abort in the first WAIT cycle
      d0 = ndone[1];
      go(1, 0, 0, t0);
      abort[1] = 1;
      @(posedge clk);
      #1 abort[1] = 0;
      chk("busy_after_wait_abort", 1, busy[1], 0);
      repeat (6) @(posedge clk);
      chk("no_done_wait_abort", 1, ndone[1] - d0, 0);
      @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end
endmodule

// File: doc/peek_dump_ctrl.md
Name: peek_dump_ctrl

Overview:
- Sequencer for the NoC-with-cores debug peek port (peek address / peek core id in, peek data out).
- On a start command it walks core ids first_id..last_id. For each core it walks word addresses 0..WORDS_PER_CORE-1, issues one peek per word and waits the fixed port read latency.
- Each captured word is presented on a valid/ready output stream tagged with core id and address.
- Replaces free-running bench sweeps with a controlled, backpressure-aware memory dump. Sits between the peek port and a host/UART/trace sink.

Parameters:
- CORE_COUNT, 9, number of cores behind the peek port; ID_W = $clog2(CORE_COUNT).
- WORDS_PER_CORE, 1024, words dumped per core. Power of two not required; must be >= 1.
- ADDR_W, 32, peek address width.
- DATA_W, 32, peek data width.
- PEEK_LAT, 1, cycles from stable peek address/id to valid peek data. Legal range 1..4.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle dump request.
- abort  in  1  terminate the dump in progress.
- first_id  in  ID_W  first core to dump, sampled on accepted start.
- last_id  in  ID_W  last core to dump (inclusive), sampled on accepted start.
- peek_address  out  ADDR_W  address to peek port (registered).
- peek_id  out  ID_W  core select to peek port (registered).
- peek_data  in  DATA_W  peek port read data.
- out_valid  out  1  stream word valid.
- out_ready  in  1  sink accepts word.
- out_data  out  DATA_W  captured word.
- out_id  out  ID_W  core id of out_data.
- out_addr  out  ADDR_W  address of out_data.
- out_last  out  1  final word of the dump (qualified by out_valid).
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the last word is accepted.
- err  out  1  one-cycle pulse on a rejected start.

Behaviour:
- Reset: state IDLE. All outputs 0: peek_address, peek_id, out_*, busy, done, err. Reset mid-dump discards everything; no done pulse.
- States: IDLE, WAIT, OUT.
- IDLE:
  - start=1 with first_id<=last_id and last_id<CORE_COUNT is accepted at edge T. At T+1: state WAIT, peek_address=0, peek_id=first_id, busy=1, latency counter=0.
  - start with an illegal range gives err=1 at T+1 and the state stays IDLE.
  - abort in IDLE has no effect.
- WAIT:
  - The counter increments each cycle.
  - At the edge ending the PEEK_LAT-th WAIT cycle, peek_data is captured into out_data. out_id and out_addr take the current peek_id and peek_address. State moves to OUT.
  - out_valid=1 from the next cycle.
  - With PEEK_LAT=1, the first word is valid at T+2.
- OUT:
  - out_valid, out_data, out_id, out_addr and out_last are held stable until out_ready=1. Unlimited stall allowed.
  - On the accept edge, out_valid drops.
    - If not last: address increments. When the address reaches WORDS_PER_CORE-1, it wraps to 0 and peek_id increments. State returns to WAIT with counter=0.
    - If last: state goes to IDLE, done=1 for one cycle, busy=0.
  - Throughput with out_ready tied high: one word every PEEK_LAT+1 cycles.
- out_last = (out_id==last_id) && (out_addr==WORDS_PER_CORE-1), asserted only while out_valid.
- peek_address and peek_id change only on the transition into WAIT. They are stable for the whole WAIT period and hold their last values in IDLE.
- start while busy is ignored (no err).
- abort while busy: state goes to IDLE at the next edge and out_valid drops. abort wins over a simultaneous out_ready or start; the pending word is discarded. No done pulse.
- Single-core dump (first_id==last_id) and WORDS_PER_CORE=1 are legal.
- Arithmetic: address compare uses the full ADDR_W width. The peek_id increment never exceeds last_id.

Test Plan:
- Reset with rst=1 for 2 cycles -> all outputs 0, busy=0. Deassert; start, first_id=0, last_id=0, PEEK_LAT=1, out_ready=1 -> 1024 words with addr 0..1023 and data matching the memory model; out_last only on addr 1023; done pulses once; busy low the cycle after done; 2048 cycles from first peek to done.
- Full dump: first_id=0, last_id=8 -> 9216 words. The id increments exactly after addr 1023 and addr wraps to 0. out_last only on id 8 / addr 1023.
- Backpressure: random out_ready (about 30% high) -> words are identical to the no-stall run and out_* are stable during each stall. Checker: the peek port is never re-addressed while out_valid=1.
- Illegal start: first_id=5, last_id=2, then last_id=9 -> err pulses each time, busy stays 0, no output words. start while busy -> ignored, dump unaffected.
- Abort at word 300 of core 2, asserted together with out_ready -> the word is not counted as accepted, IDLE next cycle, no done. A subsequent start of 3..3 dumps cleanly from addr 0.
- PEEK_LAT=3 with a model delaying data 3 cycles -> correct data; first out_valid 4 cycles after the start accept edge.
